sample_rate_scheduler: RTL and testbench

Owns the audio sample-rate divider. It accepts speed commands (faster, slower, restore default) from two requesters: the PS/2 keyboard decoder and the debounced push-buttons. It arbitrates between them and applies at most one bounded divider update per sample period, then generates the sample strobe from the active divider. Updates take effect only on a period boundary, so the downstream flash/audio reader never sees a truncated or glitched sample period.

---
 rtl/sample_rate_scheduler_if.sv | 27 ++
 rtl/sample_rate_scheduler.sv | 191 +++++++++++++++++++
 tb/tb_sample_rate_scheduler.sv | 267 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/sample_rate_scheduler_if.sv
// Command and status bundle between the speed requesters and the sample-rate scheduler.
// The master side issues keyboard strobes and button levels; the slave side owns the divider.
interface sample_rate_scheduler_if;
    logic        kbd_up;
    logic        kbd_down;
    logic        kbd_rst;
    logic        btn_up;
    logic        btn_down;
    logic        btn_rst;
    logic [31:0] div;
    logic        sample_tick;
    logic [1:0]  ack;
    logic        at_min;
    logic        at_max;

    modport master (
        output kbd_up, kbd_down, kbd_rst,
        output btn_up, btn_down, btn_rst,
        input  div, sample_tick, ack, at_min, at_max
    );

    modport slave (
        input  kbd_up, kbd_down, kbd_rst,
        input  btn_up, btn_down, btn_rst,
        output div, sample_tick, ack, at_min, at_max
    );
endinterface

// File: rtl/sample_rate_scheduler.sv
// Audio sample-rate divider: arbitrates keyboard/button speed commands, applies at most one
// bounded divider step per sample period, and times sample_tick from the active divider.
module sample_rate_scheduler #(
    parameter int unsigned DIV_DEFAULT = 32'd3472,
    parameter int unsigned DIV_MIN     = 32'd1136,
    parameter int unsigned DIV_MAX     = 32'd6944,
    parameter int unsigned STEP        = 32'd2
) (
    input logic                    clk50M,
    input logic                    rst,
    sample_rate_scheduler_if.slave bus
);

    typedef enum logic [1:0] {
        CMD_NONE = 2'd0,
        CMD_UP   = 2'd1,
        CMD_DOWN = 2'd2,
        CMD_RST  = 2'd3
    } cmd_t;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_GRANT = 2'd1,
        S_WAIT  = 2'd2
    } state_t;

    localparam logic [31:0] DEF_W   = 32'(DIV_DEFAULT);
    localparam logic [31:0] MIN_W   = 32'(DIV_MIN);
    localparam logic [31:0] MAX_W   = 32'(DIV_MAX);
    localparam logic [32:0] STEP_X  = 33'(STEP);
    localparam logic [32:0] MIN_X   = 33'(DIV_MIN);
    localparam logic [32:0] MAX_X   = 33'(DIV_MAX);
    localparam logic        MIN_RST = (DEF_W == MIN_W);
    localparam logic        MAX_RST = (DEF_W == MAX_W);

    state_t      state;
    logic        winner;
    logic        last_grant;
    logic [1:0]  ack;
    logic [31:0] div_target;
    logic        at_min;
    logic        at_max;

    logic [31:0] cnt;
    logic [31:0] div_active;
    logic        sample_tick;

    logic [2:0]  btn_level;
    logic [2:0]  btn_prev;
    logic [2:0]  btn_rise;

    cmd_t        new_cmd0;
    cmd_t        new_cmd1;
    cmd_t        pending0;
    cmd_t        pending1;
    cmd_t        granted_cmd;
    logic        any_pending;
    logic        pick;
    logic        clear0;
    logic        clear1;

    logic [32:0] up_val;
    logic [32:0] dn_val;
    logic [31:0] target_next;

    function automatic cmd_t decode(input logic r, input logic u, input logic d);
        if (r)      return CMD_RST;
        else if (u) return CMD_UP;
        else if (d) return CMD_DOWN;
        else        return CMD_NONE;
    endfunction

    // A grant empties the slot but still admits a command arriving on the same edge;
    // a pending restore is sticky so it cannot be lost to a later up/down.
    function automatic cmd_t next_pending(input cmd_t cur, input cmd_t incoming, input logic cleared);
        if (cleared)                                      return incoming;
        else if (cur != CMD_RST && incoming != CMD_NONE)  return incoming;
        else                                              return cur;
    endfunction

    assign btn_level = {bus.btn_rst, bus.btn_down, bus.btn_up};
    assign btn_rise  = btn_level & ~btn_prev;

    always_comb begin
        new_cmd0 = decode(bus.kbd_rst, bus.kbd_up, bus.kbd_down);
        new_cmd1 = decode(btn_rise[2], btn_rise[0], btn_rise[1]);
    end

    assign clear0 = (state == S_GRANT) && (winner == 1'b0);
    assign clear1 = (state == S_GRANT) && (winner == 1'b1);

    always_ff @(posedge clk50M) begin
        if (rst) begin
            btn_prev <= 3'b000;
            pending0 <= CMD_NONE;
            pending1 <= CMD_NONE;
        end else begin
            btn_prev <= btn_level;
            pending0 <= next_pending(pending0, new_cmd0, clear0);
            pending1 <= next_pending(pending1, new_cmd1, clear1);
        end
    end

    // Restore outranks stepping; otherwise ties go to the requester served less recently.
    always_comb begin
        any_pending = (pending0 != CMD_NONE) || (pending1 != CMD_NONE);
        pick        = ~last_grant;
        if (pending0 != CMD_NONE && pending1 == CMD_NONE)
            pick = 1'b0;
        else if (pending1 != CMD_NONE && pending0 == CMD_NONE)
            pick = 1'b1;
        else if (pending0 == CMD_RST && pending1 != CMD_RST)
            pick = 1'b0;
        else if (pending1 == CMD_RST && pending0 != CMD_RST)
            pick = 1'b1;
    end

    always_comb begin
        granted_cmd = winner ? pending1 : pending0;
        up_val      = {1'b0, div_target} - STEP_X;
        dn_val      = {1'b0, div_target} + STEP_X;
        target_next = div_target;
        if (state == S_GRANT) begin
            case (granted_cmd)
                CMD_UP:   target_next = (up_val[32] || up_val < MIN_X) ? MIN_W : up_val[31:0];
                CMD_DOWN: target_next = (dn_val > MAX_X) ? MAX_W : dn_val[31:0];
                CMD_RST:  target_next = DEF_W;
                default:  target_next = div_target;
            endcase
        end
    end

    // Arbiter: WAIT holds off the next grant until the current sample period has closed.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            state      <= S_IDLE;
            winner     <= 1'b0;
            last_grant <= 1'b1;
            ack        <= 2'b00;
            div_target <= DEF_W;
            at_min     <= MIN_RST;
            at_max     <= MAX_RST;
        end else begin
            ack        <= 2'b00;
            div_target <= target_next;
            at_min     <= (target_next == MIN_W);
            at_max     <= (target_next == MAX_W);
            case (state)
                S_IDLE: begin
                    if (any_pending) begin
                        winner <= pick;
                        state  <= S_GRANT;
                    end
                end
                S_GRANT: begin
                    ack        <= winner ? 2'b10 : 2'b01;
                    last_grant <= winner;
                    state      <= S_WAIT;
                end
                S_WAIT: begin
                    if (sample_tick)
                        state <= S_IDLE;
                end
                default: state <= S_IDLE;
            endcase
        end
    end

    // sample_tick is registered one count early so it is high exactly while cnt == div-1.
    always_ff @(posedge clk50M) begin
        if (rst) begin
            cnt         <= 32'd0;
            div_active  <= DEF_W;
            sample_tick <= 1'b0;
        end else if (sample_tick) begin
            cnt         <= 32'd0;
            div_active  <= div_target;
            sample_tick <= 1'b0;
        end else begin
            cnt         <= cnt + 32'd1;
            sample_tick <= (cnt == div_active - 32'd2);
        end
    end

    assign bus.div         = div_active;
    assign bus.sample_tick = sample_tick;
    assign bus.ack         = ack;
    assign bus.at_min      = at_min;
    assign bus.at_max      = at_max;

endmodule

// File: tb/tb_sample_rate_scheduler.sv
// Directed bench for sample_rate_scheduler with a small divider range (10, 6..14, step 2).
// Cycle 0 is the first cycle after reset release; inputs change just after a rising edge.
module tb_sample_rate_scheduler;

    logic clk50M = 1'b0;
    logic rst    = 1'b1;

    sample_rate_scheduler_if bus();

    sample_rate_scheduler #(
        .DIV_DEFAULT(10),
        .DIV_MIN(6),
        .DIV_MAX(14),
        .STEP(2)
    ) dut (
        .clk50M(clk50M),
        .rst(rst),
        .bus(bus)
    );

    always #10 clk50M = ~clk50M;

    typedef struct {
        int          cyc;
        logic [2:0]  kbd;   // {rst, down, up}, one-cycle pulse
        logic [2:0]  btn;   // {rst, down, up}, held level
        logic [31:0] div;
        logic [1:0]  ack;
        logic        tick;
        logic        amin;
        logic        amax;
    } vec_t;

    vec_t vecs[$];

    int cyc;
    int total;
    int passed;
    int ack0_cnt;
    int ack1_cnt;

    logic [31:0] s_div;
    logic [1:0]  s_ack;
    logic        s_tick;
    logic        s_min;
    logic        s_max;

    task automatic addVec(input int c, input logic [2:0] kbd, input logic [2:0] btn,
                          input int d, input logic [1:0] a, input logic t,
                          input logic mn, input logic mx);
        vec_t v;
        v.cyc  = c;
        v.kbd  = kbd;
        v.btn  = btn;
        v.div  = 32'(d);
        v.ack  = a;
        v.tick = t;
        v.amin = mn;
        v.amax = mx;
        vecs.push_back(v);
    endtask

    task automatic applyStimulus(input logic [2:0] kbd, input logic [2:0] btn);
        {bus.kbd_rst, bus.kbd_down, bus.kbd_up} = kbd;
        {bus.btn_rst, bus.btn_down, bus.btn_up} = btn;
    endtask

    task automatic sampleOutputs();
        @(negedge clk50M);
        s_div  = bus.div;
        s_ack  = bus.ack;
        s_tick = bus.sample_tick;
        s_min  = bus.at_min;
        s_max  = bus.at_max;
        if (s_ack[0]) ack0_cnt++;
        if (s_ack[1]) ack1_cnt++;
    endtask

    task automatic checkOutput(input string name, input int d, input logic [1:0] a,
                               input logic t, input logic mn, input logic mx);
        sampleOutputs();
        total++;
        if (s_div !== 32'(d) || s_ack !== a || s_tick !== t || s_min !== mn || s_max !== mx)
            $display("[TB] FAIL %s cycle %0d: got div=%0d ack=%b tick=%b at_min=%b at_max=%b, want div=%0d ack=%b tick=%b at_min=%b at_max=%b",
                     name, cyc, s_div, s_ack, s_tick, s_min, s_max, d, a, t, mn, mx);
        else
            passed++;
    endtask

    task automatic checkValue(input string name, input int got, input int want);
        total++;
        if (got !== want)
            $display("[TB] FAIL %s: got %0d, want %0d", name, got, want);
        else
            passed++;
    endtask

    task automatic nextCycle();
        @(posedge clk50M);
        #1;
        {bus.kbd_rst, bus.kbd_down, bus.kbd_up} = 3'b000;
        cyc++;
    endtask

    task automatic runTo(input int c);
        while (cyc < c) begin
            sampleOutputs();
            nextCycle();
        end
    endtask

    task automatic doReset();
        rst = 1'b1;
        applyStimulus(3'b000, 3'b000);
        repeat (3) @(posedge clk50M);
        #1;
        rst      = 1'b0;
        cyc      = 0;
        ack0_cnt = 0;
        ack1_cnt = 0;
    endtask

    initial begin
        #200us;
        $display("[TB] FAIL watchdog: simulation did not complete in time");
        $fatal(1, "[TB] watchdog expired");
    end

    initial begin
        total  = 0;
        passed = 0;
        applyStimulus(3'b000, 3'b000);

        // Reset state, free-run ticks and three single-step speed-ups into the lower clamp
        addVec( 0, 3'b000, 3'b000, 10, 2'b00, 1'b0, 1'b0, 1'b0);
        addVec( 8, 3'b000, 3'b000, 10, 2'b00, 1'b0, 1'b0, 1'b0);
        addVec( 9, 3'b000, 3'b000, 10, 2'b00, 1'b1, 1'b0, 1'b0);
        addVec(10, 3'b000, 3'b000, 10, 2'b00, 1'b0, 1'b0, 1'b0);
        addVec(12, 3'b001, 3'b000, 10, 2'b00, 1'b0, 1'b0, 1'b0);
        addVec(14, 3'b000, 3'b000, 10, 2'b00, 1'b0, 1'b0, 1'b0);
        addVec(15, 3'b000, 3'b000, 10, 2'b01, 1'b0, 1'b0, 1'b0);
        addVec(16, 3'b000, 3'b000, 10, 2'b00, 1'b0, 1'b0, 1'b0);
        addVec(19, 3'b000, 3'b000, 10, 2'b00, 1'b1, 1'b0, 1'b0);
        addVec(20, 3'b000, 3'b000,  8, 2'b00, 1'b0, 1'b0, 1'b0);
        addVec(26, 3'b000, 3'b000,  8, 2'b00, 1'b0, 1'b0, 1'b0);
        addVec(27, 3'b000, 3'b000,  8, 2'b00, 1'b1, 1'b0, 1'b0);
        addVec(28, 3'b001, 3'b000,  8, 2'b00, 1'b0, 1'b0, 1'b0);
        addVec(31, 3'b000, 3'b000,  8, 2'b01, 1'b0, 1'b1, 1'b0);
        addVec(35, 3'b000, 3'b000,  8, 2'b00, 1'b1, 1'b1, 1'b0);
        addVec(36, 3'b000, 3'b000,  6, 2'b00, 1'b0, 1'b1, 1'b0);
        addVec(41, 3'b000, 3'b000,  6, 2'b00, 1'b1, 1'b1, 1'b0);
        addVec(42, 3'b001, 3'b000,  6, 2'b00, 1'b0, 1'b1, 1'b0);
        addVec(45, 3'b000, 3'b000,  6, 2'b01, 1'b0, 1'b1, 1'b0);
        addVec(47, 3'b000, 3'b000,  6, 2'b00, 1'b1, 1'b1, 1'b0);
        addVec(48, 3'b000, 3'b000,  6, 2'b00, 1'b0, 1'b1, 1'b0);

        doReset();
        for (int i = 0; i < vecs.size(); i++) begin
            runTo(vecs[i].cyc);
            applyStimulus(vecs[i].kbd, vecs[i].btn);
            checkOutput($sformatf("vec%0d", i), int'(vecs[i].div), vecs[i].ack,
                        vecs[i].tick, vecs[i].amin, vecs[i].amax);
            nextCycle();
        end

        // Simultaneous kbd_down and btn_down: requester 0 first, requester 1 a period later
        doReset();
        runTo(2);
        applyStimulus(3'b010, 3'b010);
        checkOutput("dual_issue", 10, 2'b00, 1'b0, 1'b0, 1'b0);
        nextCycle();
        runTo(5);
        checkOutput("dual_ack_kbd", 10, 2'b01, 1'b0, 1'b0, 1'b0);
        nextCycle();
        runTo(9);
        checkOutput("dual_tick1", 10, 2'b00, 1'b1, 1'b0, 1'b0);
        nextCycle();
        checkOutput("dual_div12", 12, 2'b00, 1'b0, 1'b0, 1'b0);
        nextCycle();
        runTo(12);
        checkOutput("dual_ack_btn", 12, 2'b10, 1'b0, 1'b0, 1'b1);
        nextCycle();
        runTo(21);
        checkOutput("dual_tick2", 12, 2'b00, 1'b1, 1'b0, 1'b1);
        nextCycle();
        checkOutput("dual_div14", 14, 2'b00, 1'b0, 1'b0, 1'b1);
        nextCycle();
        checkValue("dual_ack0_count", ack0_cnt, 1);
        checkValue("dual_ack1_count", ack1_cnt, 1);
        applyStimulus(3'b000, 3'b000);

        // Four ups coalesce into two grants, then a held btn_rst restores exactly once
        doReset();
        applyStimulus(3'b001, 3'b000);
        checkOutput("coal_issue", 10, 2'b00, 1'b0, 1'b0, 1'b0);
        nextCycle();
        applyStimulus(3'b001, 3'b000);
        sampleOutputs();
        nextCycle();
        runTo(3);
        applyStimulus(3'b001, 3'b000);
        sampleOutputs();
        nextCycle();
        applyStimulus(3'b001, 3'b000);
        sampleOutputs();
        nextCycle();
        runTo(12);
        checkOutput("coal_ack2", 8, 2'b01, 1'b0, 1'b1, 1'b0);
        nextCycle();
        runTo(17);
        checkOutput("coal_tick", 8, 2'b00, 1'b1, 1'b1, 1'b0);
        nextCycle();
        checkOutput("coal_div6", 6, 2'b00, 1'b0, 1'b1, 1'b0);
        nextCycle();
        runTo(20);
        checkValue("coal_ack0_count", ack0_cnt, 2);
        ack0_cnt = 0;
        ack1_cnt = 0;
        applyStimulus(3'b000, 3'b100);
        runTo(24);
        checkOutput("btnrst_div10", 10, 2'b00, 1'b0, 1'b0, 1'b0);
        nextCycle();
        runTo(70);
        applyStimulus(3'b000, 3'b000);
        runTo(80);
        checkOutput("btnrst_final", 10, 2'b00, 1'b0, 1'b0, 1'b0);
        nextCycle();
        checkValue("btnrst_ack1_count", ack1_cnt, 1);
        checkValue("btnrst_ack0_count", ack0_cnt, 0);

        // Reset while WAITing with a command pending discards everything
        doReset();
        applyStimulus(3'b001, 3'b000);
        sampleOutputs();
        nextCycle();
        runTo(11);
        applyStimulus(3'b001, 3'b000);
        sampleOutputs();
        nextCycle();
        runTo(14);
        applyStimulus(3'b010, 3'b000);
        checkOutput("wait_ack", 8, 2'b01, 1'b0, 1'b1, 1'b0);
        nextCycle();
        runTo(16);
        rst = 1'b1;
        checkOutput("pre_reset", 8, 2'b00, 1'b0, 1'b1, 1'b0);
        nextCycle();
        rst      = 1'b0;
        ack0_cnt = 0;
        ack1_cnt = 0;
        checkOutput("post_reset", 10, 2'b00, 1'b0, 1'b0, 1'b0);
        nextCycle();
        runTo(26);
        checkOutput("post_reset_tick1", 10, 2'b00, 1'b1, 1'b0, 1'b0);
        nextCycle();
        runTo(36);
        checkOutput("post_reset_tick2", 10, 2'b00, 1'b1, 1'b0, 1'b0);
        nextCycle();
        runTo(45);
        checkValue("post_reset_ack0_count", ack0_cnt, 0);
        checkValue("post_reset_ack1_count", ack1_cnt, 0);

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
